// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, bit-timing derivation and frame sizes.
// Imported by both the transmitter and the receiver.
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS_NOPAR  = 10;   // start + 8 data + stop
    localparam int FRAME_BITS_PARITY = 11;   // start + 8 data + parity + stop

    // Clock cycles per bit period; integer division, callers keep this >= 4.
    function automatic int calc_bps_cnt(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int cnt_width(input int bps_cnt);
        return (bps_cnt > 2) ? $clog2(bps_cnt) : 1;
    endfunction

    function automatic int frame_cycles(input int bps_cnt, input bit parity_en);
        return bps_cnt * (parity_en ? FRAME_BITS_PARITY : FRAME_BITS_NOPAR);
    endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// Baud counter: counts 0..BPS_CNT-1 while enabled and flags TICK_AT.
// TICK_AT defaults to end-of-bit; the receiver sets it to BPS_CNT/2 for mid-bit sampling.
module uart_bps_gen
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 16,
    parameter int TICK_AT = BPS_CNT - 1
) (
    input  logic I_clk,
    input  logic I_rst,
    input  logic restart,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = cnt_width(BPS_CNT);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge I_clk) begin
        if (I_rst || restart || !enable) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(BPS_CNT - 1)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bit_tick = enable && !restart && (cnt_reg == CNT_W'(TICK_AT));

endmodule

// File: rtl/uart_txd.sv
// UART transmitter: one byte per valid/ready handshake, sent as 8N1 or 8E1/8O1.
// All outputs except O_tx_ready are registered.
module uart_txd
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_tx_start,
    input  logic       I_tx_valid,
    input  logic [7:0] I_para_data,
    output logic       O_tx_ready,
    output logic       O_rs232_txd,
    output logic       O_tx_busy,
    output logic       O_tx_done
);

    localparam int         BPS_CNT  = calc_bps_cnt(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0]           state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           index_reg;
    logic                 txd_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 accept;
    logic                 bit_tick;
    logic                 parity_bit;

    assign O_tx_ready  = (state_reg == IDLE) && I_tx_start && !I_rst;
    assign accept      = I_tx_valid && O_tx_ready;
    assign parity_bit  = (^shift_reg) ^ PARITY_ODD;

    assign O_rs232_txd = txd_reg;
    assign O_tx_busy   = busy_reg;
    assign O_tx_done   = done_reg;

    // Counter is held at zero in IDLE, so every state entry starts a fresh bit period.
    uart_bps_gen #(
        .BPS_CNT (BPS_CNT)
    ) u_bps_gen (
        .I_clk    (I_clk),
        .I_rst    (I_rst),
        .restart  (accept),
        .enable   (state_reg != IDLE),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            index_reg <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= I_para_data;
                        index_reg <= '0;
                        state_reg <= START;
                        txd_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                    end else begin
                        txd_reg <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state_reg <= DATA;
                        index_reg <= '0;
                        txd_reg   <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (index_reg == LAST_BIT) begin
                            if (PARITY_EN) begin
                                state_reg <= PARITY;
                                txd_reg   <= parity_bit;
                            end else begin
                                state_reg <= STOP;
                                txd_reg   <= 1'b1;
                            end
                        end else begin
                            index_reg <= index_reg + 3'd1;
                            txd_reg   <= shift_reg[index_reg + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state_reg <= STOP;
                        txd_reg   <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        txd_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    txd_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txd.sv
// Bench for uart_txd at 16 cycles per bit: one no-parity, one even and one odd
// parity instance, a table of hand-computed frames and a loopback receiver.
module tb_uart_txd;

    localparam int CLK_FREQ  = 160;
    localparam int BAUD_RATE = 10;
    localparam int BPS       = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       valid_np;
    logic       valid_p;
    logic [7:0] data;

    logic ready_np, txd_np, busy_np, done_np;
    logic ready_ev, txd_ev, busy_ev, done_ev;
    logic ready_od, txd_od, busy_od, done_od;

    always #5 clk = ~clk;

    uart_txd #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_np (
        .I_clk(clk), .I_rst(rst), .I_tx_start(start), .I_tx_valid(valid_np), .I_para_data(data),
        .O_tx_ready(ready_np), .O_rs232_txd(txd_np), .O_tx_busy(busy_np), .O_tx_done(done_np));

    uart_txd #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_ev (
        .I_clk(clk), .I_rst(rst), .I_tx_start(start), .I_tx_valid(valid_p), .I_para_data(data),
        .O_tx_ready(ready_ev), .O_rs232_txd(txd_ev), .O_tx_busy(busy_ev), .O_tx_done(done_ev));

    uart_txd #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_od (
        .I_clk(clk), .I_rst(rst), .I_tx_start(start), .I_tx_valid(valid_p), .I_para_data(data),
        .O_tx_ready(ready_od), .O_rs232_txd(txd_od), .O_tx_busy(busy_od), .O_tx_done(done_od));

    int   sel;
    logic ready_sel, txd_sel, busy_sel, done_sel;

    always_comb begin
        ready_sel = ready_np; txd_sel = txd_np; busy_sel = busy_np; done_sel = done_np;
        case (sel)
            1: begin ready_sel = ready_ev; txd_sel = txd_ev; busy_sel = busy_ev; done_sel = done_ev; end
            2: begin ready_sel = ready_od; txd_sel = txd_od; busy_sel = busy_od; done_sel = done_od; end
            default: ;
        endcase
    end

    // Loopback receiver on the no-parity line; rx_cnt is the cycle index within the frame.
    logic [7:0] rx_shift = 8'h00;
    int         rx_cnt   = 0;
    bit         rx_busy  = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (!rx_busy) begin
            if (txd_np === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt % BPS) == 8 && rx_cnt >= 24 && rx_cnt <= 136)
                rx_shift <= {txd_np, rx_shift[7:1]};
            if (rx_cnt == 152) begin
                rx_busy <= 1'b0;
                if (txd_np === 1'b1) rx_q.push_back(rx_shift);
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers a byte and returns at the negedge of the first start-bit cycle.
    task automatic accept_byte(input logic [7:0] d, input int which, input bit hold);
        int waited;
        @(negedge clk);
        sel  = which;
        data = d;
        if (which == 0) valid_np = 1'b1; else valid_p = 1'b1;
        #1;
        waited = 0;
        while (ready_sel !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", {31'b0, ready_sel}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            valid_np = 1'b0;
            valid_p  = 1'b0;
            data     = ~d;
        end
    endtask

    // Checks every cycle of every bit, then the done cycle right after the frame.
    task automatic check_frame(input logic [0:10] seq, input int nbits, input string tag);
        for (int b = 0; b < nbits; b++) begin
            bit ok;
            ok = 1'b1;
            for (int c = 0; c < BPS; c++) begin
                if (txd_sel !== seq[b] || busy_sel !== 1'b1 || done_sel !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d level_ok", tag, b), {31'b0, ok}, 32'd1);
        end
        check({tag, " done"}, {31'b0, done_sel}, 32'd1);
        check({tag, " busy_end"}, {31'b0, busy_sel}, 32'd0);
        check({tag, " txd_end"}, {31'b0, txd_sel}, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [0:10] seq;    // line levels in transmit order, padded with 1
        int          nbits;
        int          which;  // 0 no parity, 1 even, 2 odd
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int cyc;

        vecs[0] = '{8'hA5, 11'b01010010111, 10, 0};
        vecs[1] = '{8'h00, 11'b00000000011, 10, 0};
        vecs[2] = '{8'hFF, 11'b01111111111, 10, 0};
        vecs[3] = '{8'h55, 11'b01010101011, 10, 0};
        vecs[4] = '{8'h07, 11'b01110000011, 11, 1};
        vecs[5] = '{8'h07, 11'b01110000001, 11, 2};
        vecs[6] = '{8'h81, 11'b01000000101, 11, 1};
        vecs[7] = '{8'h81, 11'b01000000111, 11, 2};

        rst = 1'b1; start = 1'b1; valid_np = 1'b0; valid_p = 1'b0; data = 8'h00; sel = 0;

        // Reset held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d txd", i), {31'b0, txd_sel}, 32'd1);
            check($sformatf("rst%0d busy", i), {31'b0, busy_sel}, 32'd0);
            check($sformatf("rst%0d done", i), {31'b0, done_sel}, 32'd0);
            check($sformatf("rst%0d ready", i), {31'b0, ready_sel}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("release ready", {31'b0, ready_sel}, 32'd1);
        @(negedge clk);
        check("release txd", {31'b0, txd_sel}, 32'd1);

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            rx_q.delete();
            accept_byte(vecs[i].data, vecs[i].which, 1'b0);
            $display("frame %0d: data=%02h dut=%0d bits=%0d", i, vecs[i].data, vecs[i].which, vecs[i].nbits);
            check_frame(vecs[i].seq, vecs[i].nbits, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done_width", i), {31'b0, done_sel}, 32'd0);
            if (vecs[i].which == 0) begin
                check($sformatf("vec%0d rx_count", i), rx_q.size(), 32'd1);
                if (rx_q.size() > 0) check($sformatf("vec%0d rx_byte", i), {24'b0, rx_q[0]}, {24'b0, vecs[i].data});
            end
        end

        // Back-to-back 0x00 then 0xFF with valid held high
        rx_q.delete();
        accept_byte(8'h00, 0, 1'b1);
        data = 8'hFF;
        $display("frame b2b: data=00 then FF");
        check_frame(11'b00000000011, 10, "b2b0");
        check("b2b ready_at_done", {31'b0, ready_sel}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid_np = 1'b0;
        data     = 8'h11;
        check_frame(11'b01111111111, 10, "b2b1");
        check("b2b rx_count", rx_q.size(), 32'd2);
        if (rx_q.size() > 1) begin
            check("b2b rx0", {24'b0, rx_q[0]}, 32'h00);
            check("b2b rx1", {24'b0, rx_q[1]}, 32'hFF);
        end

        // Transmit enable dropped during data bit 3
        rx_q.delete();
        accept_byte(8'h3C, 0, 1'b1);
        $display("frame drop: data=3C start dropped at cycle 70");
        repeat (70) @(negedge clk);
        start = 1'b0;
        cyc = 70;
        while (done_sel !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("drop done_cycle", cyc, 32'd160);
        ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (ready_sel !== 1'b0 || txd_sel !== 1'b1 || busy_sel !== 1'b0 || done_sel !== 1'b0) ok = 1'b0;
        end
        check("drop idle_hold", {31'b0, ok}, 32'd1);
        start = 1'b1;
        #1;
        check("drop ready_back", {31'b0, ready_sel}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        valid_np = 1'b0;
        check_frame(11'b00011110011, 10, "drop2");
        check("drop rx_count", rx_q.size(), 32'd2);
        if (rx_q.size() > 1) begin
            check("drop rx0", {24'b0, rx_q[0]}, 32'h3C);
            check("drop rx1", {24'b0, rx_q[1]}, 32'h3C);
        end

        // One-cycle reset during data bit 5, then a clean frame
        accept_byte(8'hC3, 0, 1'b0);
        $display("frame reset: data=C3 reset at cycle 100");
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid txd", {31'b0, txd_sel}, 32'd1);
        check("rstmid busy", {31'b0, busy_sel}, 32'd0);
        check("rstmid done", {31'b0, done_sel}, 32'd0);
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (done_sel !== 1'b0 || txd_sel !== 1'b1) ok = 1'b0;
        end
        check("rstmid quiet", {31'b0, ok}, 32'd1);
        rx_q.delete();
        accept_byte(8'h55, 0, 1'b0);
        $display("frame after reset: data=55");
        check_frame(11'b01010101011, 10, "post");
        check("post rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) check("post rx_byte", {24'b0, rx_q[0]}, 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_txd.md
Name: uart_txd

Overview:
- UART transmitter: accepts one 8-bit parallel byte per valid/ready handshake and serialises it onto the RS-232 TX line as 8N1, or 8E1/8O1 when parity is enabled.
- Framing is start bit, data bits LSB first, optional parity bit, one stop bit.
- Pairs with the existing UART receiver on the same board link and sits between the command/response logic and the TX pin.
- Bit timing comes from an internal baud counter; no external baud clock is used.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. Cycles per bit BPS_CNT = CLK_FREQ/BAUD_RATE, integer division, must be >= 4.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, when PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- I_clk  input  1  system clock; the only clock.
- I_rst  input  1  reset, synchronous and active-high.
- I_tx_start  input  1  transmit enable. Low blocks acceptance of new frames; a frame already in progress still completes.
- I_tx_valid  input  1  I_para_data is valid this cycle.
- I_para_data  input  8  byte to send.
- O_tx_ready  output  1  block can accept a byte this cycle.
- O_rs232_txd  output  1  serial line, idle high, registered output.
- O_tx_busy  output  1  a frame is being shifted out.
- O_tx_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset values (all synchronous, all outputs registered): O_rs232_txd=1, O_tx_busy=0, O_tx_done=0, state=IDLE, baud counter=0, shift register=0, bit index=0. O_tx_ready is 0 while I_rst is high.
- O_tx_ready is combinational: (state==IDLE) and I_tx_start and not I_rst.
- Accept: the frame is accepted on a rising edge where I_tx_valid and O_tx_ready are both 1.
  - On that edge the byte is latched, state goes to START, O_rs232_txd goes 0 and O_tx_busy goes 1.
  - The start bit is therefore visible one cycle after the accepting edge.
- Data changes: I_para_data changing after acceptance has no effect on the frame.
- Baud counter: counts 0..BPS_CNT-1 and restarts at 0 on every state entry. The bit tick is cnt==BPS_CNT-1, so every bit period is exactly BPS_CNT cycles.
- States and transitions, each taken on the bit tick:
  - IDLE: txd=1.
  - START: txd=0; next state DATA with bit index 0.
  - DATA: txd=shift[index]. If index<7, increment index. If index==7, go to PARITY when PARITY_EN=1, else STOP.
  - PARITY: txd = XOR of the 8 data bits, XORed with PARITY_ODD; next state STOP.
  - STOP: txd=1. On the tick: state goes to IDLE, O_tx_done pulses high for exactly one cycle, O_tx_busy goes 0.
- Frame length: 10*BPS_CNT cycles, or 11*BPS_CNT with parity, measured from the first low txd cycle to the first IDLE cycle.
- Back-to-back: O_tx_ready is high in the first IDLE cycle, the same cycle O_tx_done is high. A byte accepted there starts its start bit on the next cycle, so there is no extra idle gap beyond the full stop bit.
- I_tx_start deasserted mid-frame: the frame finishes normally, then the block stays in IDLE with ready=0.
- I_rst mid-frame: on the next edge txd returns to 1 and all state clears. The truncated frame is not retried and O_tx_done does not pulse.
- Unused encoding: any unused state value returns to IDLE with txd=1.
- No internal FIFO: upstream holds I_tx_valid until it sees ready.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP (3 bits);
  - the BPS_CNT derivation and the counter width, clog2(BPS_CNT);
  - the frame-length constants, shared with the receiver.
- One sub-module, uart_bps_gen:
  - inputs: I_clk, I_rst, restart, enable; output: bit_tick;
  - a parameterised counter producing the end-of-bit tick;
  - reusable by the receiver as a mid-bit variant.

Test Plan (sim params CLK_FREQ=160, BAUD_RATE=10 -> BPS_CNT=16):
- Reset and idle: hold I_rst for 3 cycles then release with I_tx_start=1 -> txd=1, busy=0, done=0 throughout reset; ready=1 in the first cycle after release.
- Single byte 0xA5, PARITY_EN=0 -> starting one cycle after accept, txd carries 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. done pulses once, 160 cycles after the start-bit first cycle; busy is high for exactly 160 cycles.
- Parity: 0x07 with PARITY_EN=1, PARITY_ODD=0 -> parity bit 1. With PARITY_ODD=1 -> parity bit 0. Frame is 176 cycles.
- Back-to-back 0x00 then 0xFF with valid held high -> the second start bit begins in the cycle after done. A loopback receiver decodes 0x00 then 0xFF.
- I_tx_start dropped at data bit 3 of 0x3C, with valid still high -> the frame completes and done pulses. ready stays 0 and no second frame starts until I_tx_start=1.
- I_rst asserted for 1 cycle during data bit 5 -> txd=1 on the next cycle, busy=0, no done pulse. A new byte 0x55 sent afterwards is transmitted correctly.
